// File: rtl/uart_rx_byte.sv
// 8N1 UART receiver: synchronises the serial line, samples each bit at mid-bit
// and emits one-cycle strobes for good bytes (rx_valid) and bad stop bits (rx_frame_err).
module uart_rx_byte #(
    parameter int CLKS_PER_BIT = 104,
    parameter int SYNC_STAGES  = 2
) (
    input  logic       clk_12,
    input  logic       rst_n,
    input  logic       uart,
    output logic [7:0] rx_data,
    output logic       rx_valid,
    output logic       rx_frame_err,
    output logic       rx_busy
);

    localparam int CNT_W = $clog2(CLKS_PER_BIT);
    localparam logic [CNT_W-1:0] HALF_LAST = CNT_W'(CLKS_PER_BIT / 2 - 1);
    localparam logic [CNT_W-1:0] BIT_LAST  = CNT_W'(CLKS_PER_BIT - 1);
    localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);

    localparam logic [2:0] ST_IDLE  = 3'd0;
    localparam logic [2:0] ST_START = 3'd1;
    localparam logic [2:0] ST_DATA  = 3'd2;
    localparam logic [2:0] ST_STOP  = 3'd3;
    localparam logic [2:0] ST_BREAK = 3'd4;

    logic [SYNC_STAGES-1:0] sync_q;
    logic                   rx_s;
    logic                   rx_s_d;
    logic [2:0]             state;
    logic [CNT_W-1:0]       clk_cnt;
    logic [2:0]             bit_cnt;
    logic [7:0]             shift_q;

    // Flops reset to 1 so a line already low at release is seen as a fresh falling edge.
    always_ff @(posedge clk_12 or negedge rst_n) begin
        if (!rst_n) begin
            sync_q <= '1;
            rx_s_d <= 1'b1;
        end else begin
            sync_q <= {sync_q[SYNC_STAGES-2:0], uart};
            rx_s_d <= rx_s;
        end
    end

    assign rx_s    = sync_q[SYNC_STAGES-1];
    assign rx_busy = (state != ST_IDLE);

    always_ff @(posedge clk_12 or negedge rst_n) begin
        if (!rst_n) begin
            state        <= ST_IDLE;
            clk_cnt      <= '0;
            bit_cnt      <= 3'd0;
            shift_q      <= 8'h00;
            rx_data      <= 8'h00;
            rx_valid     <= 1'b0;
            rx_frame_err <= 1'b0;
        end else begin
            rx_valid     <= 1'b0;
            rx_frame_err <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (rx_s_d && !rx_s) begin
                        state   <= ST_START;
                        clk_cnt <= '0;
                    end
                end
                ST_START: begin
                    if (clk_cnt == HALF_LAST) begin
                        clk_cnt <= '0;
                        bit_cnt <= 3'd0;
                        state   <= rx_s ? ST_IDLE : ST_DATA;
                    end else begin
                        clk_cnt <= clk_cnt + CNT_ONE;
                    end
                end
                ST_DATA: begin
                    if (clk_cnt == BIT_LAST) begin
                        clk_cnt <= '0;
                        shift_q <= {rx_s, shift_q[7:1]};
                        bit_cnt <= bit_cnt + 3'd1;
                        if (bit_cnt == 3'd7) begin
                            state <= ST_STOP;
                        end
                    end else begin
                        clk_cnt <= clk_cnt + CNT_ONE;
                    end
                end
                ST_STOP: begin
                    // Leaving at mid-stop lets a back-to-back start edge be caught.
                    if (clk_cnt == BIT_LAST) begin
                        clk_cnt <= '0;
                        if (rx_s) begin
                            rx_data  <= shift_q;
                            rx_valid <= 1'b1;
                            state    <= ST_IDLE;
                        end else begin
                            rx_frame_err <= 1'b1;
                            state        <= ST_BREAK;
                        end
                    end else begin
                        clk_cnt <= clk_cnt + CNT_ONE;
                    end
                end
                ST_BREAK: begin
                    if (rx_s) begin
                        state <= ST_IDLE;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_uart_rx_byte.sv
// Bench for uart_rx_byte: drives serial frames and compares received strobes
// against a frame-level model of what each frame should deliver.
module tb_uart_rx_byte;

    localparam int BIT_NS = 1040;

    logic       clk_12 = 1'b0;
    logic       rst_n  = 1'b0;
    logic       uart   = 1'b1;
    logic [7:0] rx_data;
    logic       rx_valid;
    logic       rx_frame_err;
    logic       rx_busy;

    int compared   = 0;
    int mismatched = 0;

    // Model state: bytes a frame should deliver, frame errors expected, byte rx_data should hold.
    logic [7:0] exp_q[$];
    int         exp_ferr  = 0;
    logic [7:0] last_byte = 8'h00;

    // Observed events.
    logic [7:0] got_q[$];
    time        valid_t[$];
    int         ferr_cnt  = 0;
    int         both_cnt  = 0;
    bit         busy_seen = 1'b0;

    uart_rx_byte #(.CLKS_PER_BIT(104), .SYNC_STAGES(2)) dut (
        .clk_12       (clk_12),
        .rst_n        (rst_n),
        .uart         (uart),
        .rx_data      (rx_data),
        .rx_valid     (rx_valid),
        .rx_frame_err (rx_frame_err),
        .rx_busy      (rx_busy)
    );

    always #5 clk_12 = ~clk_12;

    always @(negedge clk_12) begin
        if (rst_n) begin
            if (rx_valid) begin
                got_q.push_back(rx_data);
                valid_t.push_back($time);
            end
            if (rx_frame_err) ferr_cnt++;
            if (rx_valid && rx_frame_err) both_cnt++;
            if (rx_busy) busy_seen = 1'b1;
        end
    end

    task automatic clear_records();
        exp_q.delete();
        got_q.delete();
        valid_t.delete();
        exp_ferr  = 0;
        ferr_cnt  = 0;
        both_cnt  = 0;
        busy_seen = 1'b0;
    endtask

    // A frame with stop=1 yields its byte; stop=0 yields a frame error and rx_data holds.
    // The line is left at the stop level so callers can extend a low stop bit.
    task automatic send_frame(input logic [7:0] data, input logic stop, input int bit_ns);
        if (stop) begin
            exp_q.push_back(data);
            last_byte = data;
        end else begin
            exp_ferr++;
        end
        uart = 1'b0;
        #(bit_ns);
        for (int i = 0; i < 8; i++) begin
            uart = data[i];
            #(bit_ns);
        end
        uart = stop;
        #(bit_ns);
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        uart  = 1'b1;
        #33;
        compared++;
        if (rx_data !== 8'h00) begin mismatched++; $display("FAIL reset_rx_data got %h want 00", rx_data); end
        compared++;
        if (rx_valid !== 1'b0) begin mismatched++; $display("FAIL reset_rx_valid got %b want 0", rx_valid); end
        compared++;
        if (rx_frame_err !== 1'b0) begin mismatched++; $display("FAIL reset_rx_frame_err got %b want 0", rx_frame_err); end
        compared++;
        if (rx_busy !== 1'b0) begin mismatched++; $display("FAIL reset_rx_busy got %b want 0", rx_busy); end
        @(negedge clk_12);
        rst_n = 1'b1;
        #(BIT_NS);
        compared++;
        if (rx_busy !== 1'b0) begin mismatched++; $display("FAIL idle_after_reset rx_busy got %b want 0", rx_busy); end
    endtask

    task automatic test_single();
        clear_records();
        send_frame(8'h55, 1'b1, BIT_NS);
        #500;
        compared++;
        if (got_q.size() != exp_q.size()) begin
            mismatched++; $display("FAIL single_count got %0d want %0d", got_q.size(), exp_q.size());
        end else begin
            for (int i = 0; i < exp_q.size(); i++) begin
                compared++;
                if (got_q[i] !== exp_q[i]) begin mismatched++; $display("FAIL single_byte got %h want %h", got_q[i], exp_q[i]); end
            end
        end
        compared++;
        if (ferr_cnt != exp_ferr) begin mismatched++; $display("FAIL single_ferr got %0d want %0d", ferr_cnt, exp_ferr); end
        compared++;
        if (rx_data !== last_byte) begin mismatched++; $display("FAIL single_rx_data got %h want %h", rx_data, last_byte); end
    endtask

    task automatic test_back_to_back();
        time gap;
        clear_records();
        send_frame(8'h55, 1'b1, BIT_NS);
        send_frame(8'h3F, 1'b1, BIT_NS);
        #500;
        compared++;
        if (got_q.size() != exp_q.size()) begin
            mismatched++; $display("FAIL b2b_count got %0d want %0d", got_q.size(), exp_q.size());
        end else begin
            for (int i = 0; i < exp_q.size(); i++) begin
                compared++;
                if (got_q[i] !== exp_q[i]) begin mismatched++; $display("FAIL b2b_byte%0d got %h want %h", i, got_q[i], exp_q[i]); end
            end
            gap = valid_t[1] - valid_t[0];
            compared++;
            if (gap < 10380 || gap > 10420) begin mismatched++; $display("FAIL b2b_spacing got %0t want 10400", gap); end
        end
        compared++;
        if (ferr_cnt != exp_ferr || both_cnt != 0) begin
            mismatched++; $display("FAIL b2b_ferr got %0d/%0d want %0d/0", ferr_cnt, both_cnt, exp_ferr);
        end
    endtask

    task automatic test_glitch();
        clear_records();
        uart = 1'b0;
        #300;
        uart = 1'b1;
        #2000;
        compared++;
        if (busy_seen !== 1'b1) begin mismatched++; $display("FAIL glitch_busy_pulse got %b want 1", busy_seen); end
        compared++;
        if (got_q.size() != 0 || ferr_cnt != 0) begin
            mismatched++; $display("FAIL glitch_strobes got %0d/%0d want 0/0", got_q.size(), ferr_cnt);
        end
        compared++;
        if (rx_busy !== 1'b0) begin mismatched++; $display("FAIL glitch_idle rx_busy got %b want 0", rx_busy); end
        send_frame(8'hA5, 1'b1, BIT_NS);
        #500;
        compared++;
        if (got_q.size() != 1 || got_q[0] !== exp_q[0]) begin
            mismatched++; $display("FAIL glitch_next_byte got %0d bytes data %h want %h", got_q.size(), rx_data, exp_q[0]);
        end
    endtask

    task automatic test_frame_err();
        clear_records();
        send_frame(8'h3F, 1'b0, BIT_NS);
        #(5 * BIT_NS);
        compared++;
        if (ferr_cnt != exp_ferr || got_q.size() != 0) begin
            mismatched++; $display("FAIL ferr_pulse got ferr %0d valid %0d want %0d/0", ferr_cnt, got_q.size(), exp_ferr);
        end
        compared++;
        if (rx_data !== last_byte) begin mismatched++; $display("FAIL ferr_rx_data_held got %h want %h", rx_data, last_byte); end
        compared++;
        if (rx_busy !== 1'b1) begin mismatched++; $display("FAIL ferr_break_busy got %b want 1", rx_busy); end
        uart = 1'b1;
        #500;
        compared++;
        if (rx_busy !== 1'b0) begin mismatched++; $display("FAIL ferr_release_idle got %b want 0", rx_busy); end
        send_frame(8'h12, 1'b1, BIT_NS);
        #500;
        compared++;
        if (got_q.size() != 1 || rx_data !== 8'h12 || ferr_cnt != exp_ferr) begin
            mismatched++; $display("FAIL ferr_next_byte got %0d bytes data %h ferr %0d want 1 12 %0d", got_q.size(), rx_data, ferr_cnt, exp_ferr);
        end
    endtask

    task automatic test_reset_mid_frame();
        clear_records();
        uart = 1'b0;
        #(BIT_NS);
        for (int i = 0; i < 4; i++) begin
            uart = 1'b1;
            #(BIT_NS);
        end
        #(BIT_NS / 2);
        compared++;
        if (rx_busy !== 1'b1) begin mismatched++; $display("FAIL midreset_busy_before got %b want 1", rx_busy); end
        rst_n = 1'b0;
        last_byte = 8'h00;
        #20;
        compared++;
        if (rx_data !== 8'h00 || rx_valid !== 1'b0 || rx_frame_err !== 1'b0 || rx_busy !== 1'b0) begin
            mismatched++;
            $display("FAIL midreset_outputs got %h %b %b %b want 00 0 0 0", rx_data, rx_valid, rx_frame_err, rx_busy);
        end
        #(2 * BIT_NS - 20);
        rst_n = 1'b1;
        #(2 * BIT_NS);
        compared++;
        if (got_q.size() != 0 || ferr_cnt != 0 || rx_busy !== 1'b0) begin
            mismatched++; $display("FAIL midreset_no_strobe got %0d/%0d busy %b want 0/0 0", got_q.size(), ferr_cnt, rx_busy);
        end
        send_frame(8'h81, 1'b1, BIT_NS);
        #500;
        compared++;
        if (got_q.size() != 1 || got_q[0] !== exp_q[0]) begin
            mismatched++; $display("FAIL midreset_next_byte got %0d bytes data %h want %h", got_q.size(), rx_data, exp_q[0]);
        end
    endtask

    task automatic test_baud_skew();
        int skews[2];
        skews[0] = 1010;
        skews[1] = 1070;
        for (int s = 0; s < 2; s++) begin
            clear_records();
            send_frame(8'h55, 1'b1, skews[s]);
            send_frame(8'h3F, 1'b1, skews[s]);
            #500;
            compared++;
            if (got_q.size() != exp_q.size() || ferr_cnt != 0) begin
                mismatched++; $display("FAIL skew%0d_count got %0d ferr %0d want %0d", skews[s], got_q.size(), ferr_cnt, exp_q.size());
            end else begin
                for (int i = 0; i < exp_q.size(); i++) begin
                    compared++;
                    if (got_q[i] !== exp_q[i]) begin mismatched++; $display("FAIL skew%0d_byte%0d got %h want %h", skews[s], i, got_q[i], exp_q[i]); end
                end
            end
        end
    endtask

    task automatic test_random();
        clear_records();
        for (int n = 0; n < 10; n++) begin
            send_frame(8'($urandom_range(0, 255)), 1'b1, 10 * $urandom_range(101, 107));
            #(10 * $urandom_range(0, 50));
        end
        #500;
        compared++;
        if (got_q.size() != exp_q.size() || ferr_cnt != 0 || both_cnt != 0) begin
            mismatched++; $display("FAIL random_count got %0d ferr %0d want %0d", got_q.size(), ferr_cnt, exp_q.size());
        end else begin
            for (int i = 0; i < exp_q.size(); i++) begin
                compared++;
                if (got_q[i] !== exp_q[i]) begin mismatched++; $display("FAIL random_byte%0d got %h want %h", i, got_q[i], exp_q[i]); end
            end
        end
        compared++;
        if (rx_data !== last_byte) begin mismatched++; $display("FAIL random_rx_data got %h want %h", rx_data, last_byte); end
    endtask

    initial begin
        test_reset();
        test_single();
        test_back_to_back();
        test_glitch();
        test_frame_err();
        test_reset_mid_frame();
        test_baud_skew();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
